// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, sequencer state encoding and icodes.
// STEP_DEBUG_EN adds the PAUSE state used for single-stepping.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_MEMORY    = 4'd4,
    S_WRITEBACK = 4'd5,
    S_PCUPD     = 4'd6,
`ifdef STEP_DEBUG_EN
    S_STOP      = 4'd7,
    S_PAUSE     = 4'd8
`else
    S_STOP      = 4'd7
`endif
  } ctrl_state_t;

  function automatic logic is_stage_state(input ctrl_state_t s);
    return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXECUTE) ||
           (s == S_MEMORY) || (s == S_WRITEBACK) || (s == S_PCUPD);
  endfunction

endpackage

// File: rtl/seq_perf_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^CNT_W.
module seq_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr)      r_count <= '0;
    else if (inc) r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/seq_stage_controller.sv
// Y86-64 SEQ multi-cycle sequencer: owns PC, issues one-hot stage enables, folds faults into stat.
// STEP_DEBUG_EN adds step/paused ports and a PAUSE state after each PC update.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | fetch enabled; faults/halt sampled on exit
// DECODE    | decode enabled
// EXECUTE   | execute enabled
// MEMORY    | memory enabled; dmem_error sampled on exit
// WRITEBACK | writeback enabled
// PCUPD     | pc <= updated_pc, instruction retired
// PAUSE     | (STEP_DEBUG_EN) waiting for a step pulse
// STOP      | terminal until reset
module seq_stage_controller
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MAX_INSTR = 0,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic [63:0]      updated_pc,
`ifdef STEP_DEBUG_EN
  input  logic             step,
  output logic             paused,
`endif
  output logic [63:0]      pc,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             execute_en,
  output logic             memory_en,
  output logic             writeback_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic             limit_hit,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  ctrl_state_t      r_state;
  ctrl_state_t      w_next_state;
  logic [63:0]      r_pc;
  logic [2:0]       r_stat;
  logic [2:0]       w_stat_next;
  logic             r_limit_hit;
  logic             w_limit_set;
  logic             w_busy;
  logic [CNT_W-1:0] w_cycle_count;
  logic [CNT_W-1:0] w_instr_count;
  logic [CNT_W-1:0] w_instr_next;
  logic             w_limit_reached;

  assign w_busy          = is_stage_state(r_state);
  assign w_instr_next    = w_instr_count + 1'b1;
  assign w_limit_reached = (MAX_INSTR != 0) && (w_instr_next == CNT_W'(MAX_INSTR));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_stat      <= STAT_AOK;
      r_limit_hit <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_stat  <= w_stat_next;
      if (r_state == S_PCUPD) r_pc <= updated_pc;
      if (w_limit_set)        r_limit_hit <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_stat_next  = r_stat;
    w_limit_set  = 1'b0;
    case (r_state)
      S_IDLE:      if (start) w_next_state = S_FETCH;
      S_FETCH: begin
        // Fault priority: address error, then illegal instruction, then halt.
        if (imem_error) begin
          w_next_state = S_STOP;
          w_stat_next  = STAT_ADR;
        end else if (!instr_valid) begin
          w_next_state = S_STOP;
          w_stat_next  = STAT_INS;
        end else if (halt) begin
          w_next_state = S_STOP;
          w_stat_next  = STAT_HLT;
        end else begin
          w_next_state = S_DECODE;
        end
      end
      S_DECODE:    w_next_state = S_EXECUTE;
      S_EXECUTE:   w_next_state = S_MEMORY;
      S_MEMORY: begin
        if (dmem_error) begin
          w_next_state = S_STOP;
          w_stat_next  = STAT_ADR;
        end else begin
          w_next_state = S_WRITEBACK;
        end
      end
      S_WRITEBACK: w_next_state = S_PCUPD;
      S_PCUPD: begin
        if (w_limit_reached) begin
          w_next_state = S_STOP;
          w_limit_set  = 1'b1;
        end else begin
`ifdef STEP_DEBUG_EN
          w_next_state = S_PAUSE;
`else
          w_next_state = S_FETCH;
`endif
        end
      end
`ifdef STEP_DEBUG_EN
      S_PAUSE:     if (step) w_next_state = S_FETCH;
`endif
      S_STOP:      w_next_state = S_STOP;
      default:     w_next_state = S_IDLE;
    endcase
  end

  seq_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (w_busy),
    .count (w_cycle_count)
  );

  seq_perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (r_state == S_PCUPD),
    .count (w_instr_count)
  );

  assign pc           = r_pc;
  assign fetch_en     = (r_state == S_FETCH);
  assign decode_en    = (r_state == S_DECODE);
  assign execute_en   = (r_state == S_EXECUTE);
  assign memory_en    = (r_state == S_MEMORY);
  assign writeback_en = (r_state == S_WRITEBACK);
  assign pc_en        = (r_state == S_PCUPD);
  assign stat         = r_stat;
  assign busy         = w_busy;
  assign limit_hit    = r_limit_hit;
  assign cycle_count  = w_cycle_count;
  assign instr_count  = w_instr_count;
`ifdef STEP_DEBUG_EN
  assign paused       = (r_state == S_PAUSE);
`endif

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed self-checking bench for seq_stage_controller (unlimited instance plus a MAX_INSTR=3 instance).
module tb_seq_stage_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_on = 1'b0;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic [63:0] pc_step = 64'd1;
  logic        step = 1'b1;
  logic        halt, dmem_error;
  logic [63:0] updated_pc, pc;
  logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en;
  logic [2:0]  stat;
  logic        busy, limit_hit;
  logic [31:0] cycle_count, instr_count;
  logic        paused;

  logic [63:0] l_pc;
  logic        l_fe, l_de, l_ee, l_me, l_we, l_pe, l_busy, l_limit, l_paused;
  logic [2:0]  l_stat;
  logic [31:0] l_cyc, l_ins;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign halt       = halt_on && (pc == 64'd2);
  assign dmem_error = (pc == 64'd10);
  assign updated_pc = pc + pc_step;

  seq_stage_controller dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_error(dmem_error), .updated_pc(updated_pc),
`ifdef STEP_DEBUG_EN
    .step(step), .paused(paused),
`endif
    .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .writeback_en(writeback_en), .pc_en(pc_en), .stat(stat),
    .busy(busy), .limit_hit(limit_hit), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  seq_stage_controller #(.MAX_INSTR(3)) dut_lim (
    .clk(clk), .reset(reset), .start(start), .halt(1'b0), .instr_valid(1'b1),
    .imem_error(1'b0), .dmem_error(1'b0), .updated_pc(l_pc + 64'd1),
`ifdef STEP_DEBUG_EN
    .step(step), .paused(l_paused),
`endif
    .pc(l_pc), .fetch_en(l_fe), .decode_en(l_de), .execute_en(l_ee),
    .memory_en(l_me), .writeback_en(l_we), .pc_en(l_pe), .stat(l_stat),
    .busy(l_busy), .limit_hit(l_limit), .cycle_count(l_cyc), .instr_count(l_ins)
  );

`ifndef STEP_DEBUG_EN
  assign paused   = 1'b0;
  assign l_paused = 1'b0;
`endif

  wire [5:0] en = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic seen;
  int   k;

  initial begin
    // Reset state
    do_reset();
    chk("rst_pc", pc, 64'd0);
    chk("rst_en", {58'd0, en}, 64'd0);
    chk("rst_stat", {61'd0, stat}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_limit", {63'd0, limit_hit}, 64'd0);
    chk("rst_cyc", {32'd0, cycle_count}, 64'd0);
    chk("rst_ins", {32'd0, instr_count}, 64'd0);

    // nop; nop; halt
    halt_on = 1'b1;
    pulse_start();
    chk("t1_fetch_en", {58'd0, en}, 64'h20);
    chk("t1_pc0", pc, 64'd0);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      chk("t1_stage_seq", {58'd0, en}, {58'd0, 6'h20 >> i});
    end
    @(negedge clk);
    chk("t1_pc1", pc, 64'd1);
    chk("t1_start_ignored", {58'd0, en}, 64'h20);
    k = 0;
    while (stat == 3'd1 && k < 40) begin @(negedge clk); k++; end
    chk("t1_timeout", {63'd0, k < 40}, 64'd1);
    chk("t1_stat_hlt", {61'd0, stat}, 64'd2);
    chk("t1_pc2", pc, 64'd2);
    chk("t1_ins", {32'd0, instr_count}, 64'd2);
    chk("t1_cyc", {32'd0, cycle_count}, 64'd13);
    chk("t1_busy", {63'd0, busy}, 64'd0);
    pulse_start();
    @(negedge clk);
    chk("t1_stop_holds", {58'd0, en}, 64'd0);
    halt_on = 1'b0;

    // imem_error and !instr_valid together: ADR wins
    do_reset();
    imem_error = 1'b1;
    instr_valid = 1'b0;
    pulse_start();
    chk("t2_fetch_en", {58'd0, en}, 64'h20);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (decode_en) seen = 1'b1;
    end
    chk("t2_stat_adr", {61'd0, stat}, 64'd3);
    chk("t2_no_decode", {63'd0, seen}, 64'd0);
    chk("t2_pc", pc, 64'd0);
    chk("t2_cyc", {32'd0, cycle_count}, 64'd1);
    imem_error = 1'b0;
    instr_valid = 1'b1;

    // irmovq (10 bytes) then mrmovq faulting in MEMORY
    do_reset();
    pc_step = 64'd10;
    pulse_start();
    seen = 1'b0;
    k = 0;
    while (stat == 3'd1 && k < 40) begin
      if (pc == 64'd10 && writeback_en) seen = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("t3_timeout", {63'd0, k < 40}, 64'd1);
    chk("t3_stat_adr", {61'd0, stat}, 64'd3);
    chk("t3_no_wb", {63'd0, seen}, 64'd0);
    chk("t3_pc", pc, 64'd10);
    chk("t3_ins", {32'd0, instr_count}, 64'd1);
    chk("t3_cyc", {32'd0, cycle_count}, 64'd10);
    pc_step = 64'd1;

    // MAX_INSTR=3 with endless nops
    do_reset();
    pulse_start();
    k = 0;
    while (!l_limit && k < 60) begin @(negedge clk); k++; end
    chk("t4_timeout", {63'd0, k < 60}, 64'd1);
    chk("t4_limit", {63'd0, l_limit}, 64'd1);
    chk("t4_stat_aok", {61'd0, l_stat}, 64'd1);
    chk("t4_ins", {32'd0, l_ins}, 64'd3);
    chk("t4_cyc", {32'd0, l_cyc}, 64'd18);
    chk("t4_pc", l_pc, 64'd3);
    repeat (3) @(negedge clk);
    chk("t4_stopped", {57'd0, l_busy, l_fe, l_de, l_ee, l_me, l_we, l_pe}, 64'd0);

    // Reset during EXECUTE of the second instruction
    do_reset();
    pulse_start();
    repeat (8) @(negedge clk);
    chk("t5_in_execute", {58'd0, en}, 64'h08);
    chk("t5_pc_before", pc, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_pc", pc, 64'd0);
    chk("t5_en", {58'd0, en}, 64'd0);
    chk("t5_cnt", {cycle_count, instr_count}, 64'd0);
    chk("t5_stat", {61'd0, stat}, 64'd1);
    @(negedge clk);
    chk("t5_idle", {63'd0, busy}, 64'd0);

`ifdef STEP_DEBUG_EN
    do_reset();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    chk("t6_step_idle", {62'd0, busy, paused}, 64'd0);
    pulse_start();
    repeat (6) @(negedge clk);
    chk("t6_paused1", {63'd0, paused}, 64'd1);
    chk("t6_en_paused", {58'd0, en}, 64'd0);
    @(negedge clk);
    chk("t6_still_paused", {63'd0, paused}, 64'd1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("t6_fetch_after_step", {58'd0, en}, 64'h20);
    chk("t6_pc1", pc, 64'd1);
    repeat (6) @(negedge clk);
    chk("t6_paused2", {63'd0, paused}, 64'd1);
    chk("t6_ins", {32'd0, instr_count}, 64'd2);
    step = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
